// File: rtl/ladybird_fetch.sv
// Instruction fetch stage: issues word reads under a credit limit, queues returned
// words with their PCs in order, and flushes/discards stale traffic on redirect.
module ladybird_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [31:0] pc;
    cnt_t        count;
    cnt_t        inflight;
    cnt_t        drop;
    ptr_t        q_head;
    ptr_t        q_tail;
    ptr_t        f_head;
    ptr_t        f_tail;

    logic [31:0] q_inst [QUEUE_DEPTH];
    logic [31:0] q_pc   [QUEUE_DEPTH];
    logic [31:0] f_pc   [QUEUE_DEPTH];

    logic        grant;
    logic        push;
    logic        pop;
    logic [31:0] resp_pc;
    logic [31:0] pc_next;
    cnt_t        count_next;
    cnt_t        inflight_next;
    cnt_t        drop_next;
    logic        req_next;
    logic        head_load;
    logic [31:0] head_inst_next;
    logic [31:0] head_pc_next;

    // Alignment bits of the redirect target are deliberately ignored.
    logic        unused_rpc_lsb;
    assign unused_rpc_lsb = ^redirect_pc[1:0];

    assign grant         = mem_req & mem_gnt;
    assign push          = mem_rvalid & ~redirect_valid & (drop == '0);
    assign pop           = out_valid & out_ready & ~redirect_valid;
    assign resp_pc       = f_pc[f_head];
    assign inflight_next = inflight + cnt_t'(grant) - cnt_t'(mem_rvalid);
    assign mem_addr      = pc;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pc_next        = pc;
        drop_next      = drop;
        count_next     = count + cnt_t'(push) - cnt_t'(pop);
        head_load      = 1'b0;
        head_inst_next = out_inst;
        head_pc_next   = out_pc;

        if (grant) begin
            pc_next = pc + 32'd4;
        end
        if (mem_rvalid && (drop != '0)) begin
            drop_next = drop - cnt_t'(1);
        end

        // The head register always mirrors the oldest queued entry.
        if (pop && (count > cnt_t'(1))) begin
            head_load      = 1'b1;
            head_inst_next = q_inst[q_head + ptr_t'(1)];
            head_pc_next   = q_pc[q_head + ptr_t'(1)];
        end else if (push && ((count == '0) || (pop && (count == cnt_t'(1))))) begin
            head_load      = 1'b1;
            head_inst_next = mem_rdata;
            head_pc_next   = resp_pc;
        end

        if (redirect_valid) begin
            pc_next    = {redirect_pc[31:2], 2'b00};
            count_next = '0;
            drop_next  = inflight_next;
            head_load  = 1'b0;
        end
    end

    // Credits freed this cycle only become visible through the registered request.
    assign req_next = (SW'(count_next) + SW'(inflight_next)) < SW'(QUEUE_DEPTH);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pc        <= START_PC;
            count     <= '0;
            inflight  <= '0;
            drop      <= '0;
            q_head    <= '0;
            q_tail    <= '0;
            f_head    <= '0;
            f_tail    <= '0;
            mem_req   <= 1'b0;
            out_valid <= 1'b0;
            out_inst  <= NOP;
            out_pc    <= '0;
        end else begin
            pc        <= pc_next;
            count     <= count_next;
            inflight  <= inflight_next;
            drop      <= drop_next;
            mem_req   <= req_next;
            out_valid <= (count_next != '0);

            if (push) begin
                q_tail <= q_tail + ptr_t'(1);
            end
            if (redirect_valid) begin
                q_head <= q_tail;
            end else if (pop) begin
                q_head <= q_head + ptr_t'(1);
            end
            if (grant) begin
                f_tail <= f_tail + ptr_t'(1);
            end
            if (mem_rvalid) begin
                f_head <= f_head + ptr_t'(1);
            end
            if (head_load) begin
                out_inst <= head_inst_next;
                out_pc   <= head_pc_next;
            end
        end
    end

    // NOTE: storage arrays carry no reset; occupancy counters alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[q_tail] <= mem_rdata;
            q_pc[q_tail]   <= resp_pc;
        end
        if (grant) begin
            f_pc[f_tail] <= pc;
        end
    end

    a_rvalid_has_inflight: assert property (@(posedge clk) disable iff (!nrst)
        mem_rvalid |-> (inflight != '0));
    a_credit_cap: assert property (@(posedge clk) disable iff (!nrst)
        (SW'(count) + SW'(inflight)) <= SW'(QUEUE_DEPTH));
    a_drop_le_inflight: assert property (@(posedge clk) disable iff (!nrst)
        drop <= inflight);

endmodule

// File: tb/tb_ladybird_fetch.sv
// Self-checking bench for ladybird_fetch: directed vector table, hand-written
// redirect/reset sequences, and a randomized run against a transaction-level model.
module tb_ladybird_fetch;

    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC0  = 32'h0000_0000;
    localparam logic [31:0] ADDI  = 32'h0050_0093;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    ladybird_fetch #(.RESET_PC(RPC0), .QUEUE_DEPTH(DEPTH)) dut (
        .clk(clk), .nrst(nrst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    // Model: outstanding fetches (oldest first) and words awaiting decode.
    typedef struct { logic [31:0] addr; bit stale; int due; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct {
        bit rst; bit g; bit rv; logic [31:0] rd; bit rdy; bit rdr; logic [31:0] rpc;
        bit e_req; logic [31:0] e_addr; bit e_ov; logic [31:0] e_pc;
    } vec_t;

    pend_t       pending[$];
    ent_t        mq[$];
    logic [31:0] fetch_pc;
    bit          started;
    int          cyc;
    int          n_checks;
    int          n_fail;
    int          n_pops;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic bit exp_req();
        return started && ((mq.size() + pending.size()) < DEPTH);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        pending.delete();
        mq.delete();
        fetch_pc = {RPC0[31:2], 2'b00};
        started  = 1'b0;
    endtask

    task automatic clear_inputs();
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, RPC0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_inst"}, out_inst, NOP);
        check({tag, "_out_pc"}, out_pc, 32'd0);
    endtask

    task automatic do_reset();
        clear_inputs();
        nrst = 1'b1;
        #1 nrst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");
        @(negedge clk);
        nrst = 1'b1;
        model_reset();
    endtask

    task automatic model_check();
        check("model_mem_req", 32'(mem_req), 32'(exp_req()));
        check("model_mem_addr", mem_addr, fetch_pc);
        check("model_out_valid", 32'(out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("model_out_pc", out_pc, mq[0].pc);
            check("model_out_inst", out_inst, mq[0].inst);
        end
    endtask

    task automatic expect_out(input string name, input bit req, input logic [31:0] addr,
                              input bit ov, input logic [31:0] pc, input logic [31:0] inst);
        check({name, "_req"}, 32'(mem_req), 32'(req));
        check({name, "_addr"}, mem_addr, addr);
        check({name, "_ov"}, 32'(out_valid), 32'(ov));
        if (ov) begin
            check({name, "_pc"}, out_pc, pc);
            check({name, "_inst"}, out_inst, inst);
        end
    endtask

    // One cycle: check against the model, drive inputs, advance the model, wait.
    task automatic step(input bit g, input bit rv, input logic [31:0] rd,
                        input bit rdy, input bit rdr, input logic [31:0] rpc);
        pend_t e;
        bit    ov0;
        bit    req0;
        model_check();
        if (pending.size() == 0) rv = 1'b0;
        mem_gnt = g; mem_rvalid = rv; mem_rdata = rd;
        out_ready = rdy; redirect_valid = rdr; redirect_pc = rpc;
        ov0  = (mq.size() > 0);
        req0 = exp_req();
        e    = '{addr: '0, stale: 1'b1, due: 0};
        if (rv) e = pending.pop_front();
        if (!rdr && ov0 && rdy) begin
            mq.delete(0);
            n_pops++;
        end
        if (rv && !e.stale && !rdr) mq.push_back('{pc: e.addr, inst: rd});
        if (req0 && g) begin
            pending.push_back('{addr: fetch_pc, stale: rdr, due: cyc + 1});
            fetch_pc += 32'd4;
        end
        if (rdr) begin
            foreach (pending[i]) pending[i].stale = 1'b1;
            mq.delete();
            fetch_pc = {rpc[31:2], 2'b00};
        end
        cyc++;
        @(negedge clk);
        started = 1'b1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    vec_t vecs[$];

    function automatic vec_t v(input bit g, input bit rv, input bit rdy,
                               input bit e_req, input logic [31:0] e_addr,
                               input bit e_ov, input logic [31:0] e_pc);
        return '{rst: 1'b0, g: g, rv: rv, rd: ADDI, rdy: rdy, rdr: 1'b0, rpc: '0,
                 e_req: e_req, e_addr: e_addr, e_ov: e_ov, e_pc: e_pc};
    endfunction

    function automatic vec_t vrst();
        vec_t r;
        r = v(0, 0, 0, 0, 0, 0, 0);
        r.rst = 1'b1;
        return r;
    endfunction

    initial begin
        bit          g;
        bit          rv;
        bit          rdy;
        bit          rdr;
        logic [31:0] rd;
        logic [31:0] rpc;

        n_checks = 0; n_fail = 0; n_pops = 0; cyc = 0;
        model_reset();

        // Streaming with out_ready=1: 0x0 appears two cycles after the first grant.
        vecs.push_back(vrst());
        vecs.push_back(v(1, 0, 1, 0, 32'h00, 0, 0));
        vecs.push_back(v(1, 0, 1, 1, 32'h00, 0, 0));
        vecs.push_back(v(1, 1, 1, 1, 32'h04, 0, 0));
        vecs.push_back(v(1, 1, 1, 0, 32'h08, 1, 32'h00));
        vecs.push_back(v(1, 0, 1, 1, 32'h08, 1, 32'h04));
        vecs.push_back(v(1, 1, 1, 1, 32'h0C, 0, 0));
        vecs.push_back(v(1, 1, 1, 0, 32'h10, 1, 32'h08));
        vecs.push_back(v(0, 0, 0, 1, 32'h10, 1, 32'h0C));
        // Decoder stalled: two grants fill the credits, then drain and resume at 0x8.
        vecs.push_back(vrst());
        vecs.push_back(v(1, 0, 0, 0, 32'h00, 0, 0));
        vecs.push_back(v(1, 0, 0, 1, 32'h00, 0, 0));
        vecs.push_back(v(1, 1, 0, 1, 32'h04, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 32'h08, 1, 32'h00));
        vecs.push_back(v(1, 0, 0, 0, 32'h08, 1, 32'h00));
        vecs.push_back(v(1, 0, 1, 0, 32'h08, 1, 32'h00));
        vecs.push_back(v(1, 0, 1, 1, 32'h08, 1, 32'h04));
        vecs.push_back(v(1, 1, 1, 1, 32'h0C, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 32'h10, 1, 32'h08));
        vecs.push_back(v(0, 0, 0, 1, 32'h10, 1, 32'h0C));

        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                do_reset();
            end else begin
                expect_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr,
                           vecs[i].e_ov, vecs[i].e_pc, ADDI);
                step(vecs[i].g, vecs[i].rv, vecs[i].rd, vecs[i].rdy, vecs[i].rdr, vecs[i].rpc);
            end
        end

        // Redirect with one response in flight: that response is dropped.
        do_reset();
        idle();
        expect_out("redir_a1", 1, 32'h0, 0, 0, 0);
        step(1, 0, '0, 1, 0, '0);
        expect_out("redir_a2", 1, 32'h4, 0, 0, 0);
        step(0, 0, '0, 1, 1, 32'h0000_0103);
        expect_out("redir_a3", 1, 32'h100, 0, 0, 0);
        step(1, 1, word_of(32'h0), 1, 0, '0);
        expect_out("redir_a4", 1, 32'h104, 0, 0, 0);
        step(0, 1, word_of(32'h100), 0, 0, '0);
        expect_out("redir_a5", 1, 32'h104, 1, 32'h100, word_of(32'h100));
        idle();

        // Redirect coinciding with a grant and a response.
        do_reset();
        idle();
        step(1, 0, '0, 1, 0, '0);
        expect_out("redir_b2", 1, 32'h4, 0, 0, 0);
        step(1, 1, word_of(32'h0), 1, 1, 32'h0000_0200);
        expect_out("redir_b3", 1, 32'h200, 0, 0, 0);
        step(1, 1, word_of(32'h4), 1, 0, '0);
        expect_out("redir_b4", 1, 32'h204, 0, 0, 0);
        step(0, 1, word_of(32'h200), 0, 0, '0);
        expect_out("redir_b5", 1, 32'h204, 1, 32'h200, word_of(32'h200));
        idle();

        // Grant withheld for five cycles; redirect in the third.
        do_reset();
        idle();
        for (int k = 1; k <= 5; k++) begin
            expect_out($sformatf("hold%0d", k), 1, (k <= 3) ? 32'h0 : 32'h40, 0, 0, 0);
            step(0, 0, '0, 0, (k == 3), 32'h0000_0040);
        end

        // Address wrap at the top of the space.
        do_reset();
        idle();
        step(0, 0, '0, 0, 1, 32'hFFFF_FFFF);
        expect_out("wrap2", 1, 32'hFFFF_FFFC, 0, 0, 0);
        step(1, 0, '0, 0, 0, '0);
        expect_out("wrap3", 1, 32'h0, 0, 0, 0);
        step(1, 1, word_of(32'hFFFF_FFFC), 0, 0, '0);
        expect_out("wrap4", 0, 32'h4, 1, 32'hFFFF_FFFC, word_of(32'hFFFF_FFFC));
        step(0, 1, word_of(32'h0), 1, 0, '0);
        expect_out("wrap5", 1, 32'h4, 1, 32'h0, word_of(32'h0));
        idle();

        // Asynchronous reset with an entry queued and a fetch in flight.
        do_reset();
        idle();
        step(1, 0, '0, 0, 0, '0);
        step(1, 1, word_of(32'h0), 0, 0, '0);
        expect_out("midrst_pre", 0, 32'h8, 1, 32'h0, word_of(32'h0));
        #2 nrst = 1'b0;
        #1 check_reset_values("midrst");
        clear_inputs();
        model_reset();
        @(negedge clk);
        nrst = 1'b1;
        expect_out("midrst_c0", 0, RPC0, 0, 0, 0);
        idle();
        expect_out("midrst_c1", 1, RPC0, 0, 0, 0);
        step(1, 0, '0, 1, 0, '0);
        expect_out("midrst_c2", 1, RPC0 + 32'd4, 0, 0, 0);
        idle();

        // Randomized traffic against the model.
        do_reset();
        n_pops = 0;
        for (int k = 0; k < 3000; k++) begin
            g   = ($urandom_range(0, 9) < 6);
            rv  = 1'b0;
            rd  = $urandom();
            if (pending.size() > 0) begin
                if ((pending[0].due <= cyc) && ($urandom_range(0, 9) < 6)) begin
                    rv = 1'b1;
                    rd = word_of(pending[0].addr);
                end
            end
            rdy = ($urandom_range(0, 9) < 7);
            rdr = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 2))
                0:       rpc = $urandom();
                1:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: rpc = 32'h0000_1000 + 32'($urandom_range(0, 255));
            endcase
            step(g, rv, rd, rdy, rdr, rpc);
        end
        check("random_progress", 32'(n_pops >= 150), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
